// File: rtl/window_gen_3x3.sv
// 3x3 neighbourhood builder: two line buffers feed a 3x3 tap array.
// Emits each complete, non-padded window with a one-cycle strobe.
module window_gen_3x3 #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  pix_valid,
    output logic [9*DATA_W-1:0]   window,
    output logic                  win_valid,
    output logic                  frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] tap [9];
    logic              col_last;
    logic              row_last;
    logic              full;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign full     = (row >= RW'(2)) && (col >= CW'(2));

    // Line buffers hold no reset: rows r<2 never raise win_valid.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[col] <= pix_in;
            lb2[col] <= lb1[col];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                tap[i] <= '0;
            end
        end else begin
            win_valid  <= pix_valid && full;
            frame_done <= pix_valid && col_last && row_last;
            if (pix_valid) begin
                for (int wr = 0; wr < 3; wr++) begin
                    tap[3*wr]     <= tap[3*wr+1];
                    tap[3*wr+1]   <= tap[3*wr+2];
                end
                tap[2] <= lb2[col];
                tap[5] <= lb1[col];
                tap[8] <= pix_in;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_pack
        assign window[i*DATA_W +: DATA_W] = tap[i];
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: directed frames plus random pixels/gaps,
// checked against an image-array reference model.
module tb_window_gen_3x3;

    localparam int W = 4;
    localparam int H = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [D-1:0]   pix_in = '0;
    logic           pix_valid = 1'b0;
    logic [9*D-1:0] window;
    logic           win_valid;
    logic           frame_done;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .window     (window),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int             mr = 0;
    int             mc = 0;
    logic [D-1:0]   img [H][W];
    logic [9*D-1:0] last_exp = '0;
    bit             known = 0;
    logic [9*D-1:0] got [$];
    logic [9*D-1:0] ref1 [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [D-1:0] p);
        bit             ev;
        bit             ef;
        logic [9*D-1:0] ew;
        ev = 0;
        ef = 0;
        ew = '0;
        pix_valid = v;
        pix_in    = p;
        if (v) begin
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                ev = 1;
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        ew[(3*wr+wc)*D +: D] = img[mr-2+wr][mc-2+wc];
                ef = (mr == H-1) && (mc == W-1);
            end
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
        chk("win_valid", 64'(win_valid), 64'(ev));
        chk("frame_done", 64'(frame_done), 64'(ef));
        if (ev) begin
            chk("window", 64'(window), 64'(ew));
            last_exp = ew;
            known = 1;
            got.push_back(window);
        end else if (v) begin
            known = 0;
        end else if (known) begin
            chk("window_hold", 64'(window), 64'(last_exp));
        end
        pix_valid = 0;
    endtask

    // kind: 0 raster idx, 1 15-idx, 2 all 4'b1000, 3 random
    // gaps: 0 none, 1 two idles per pixel + 5 at row end, 2 random
    task automatic frame(input int kind, input int gaps, input int npix);
        logic [D-1:0] p;
        for (int idx = 0; idx < npix; idx++) begin
            case (kind)
                0:       p = D'(idx);
                1:       p = D'(15 - idx);
                2:       p = 4'b1000;
                default: p = D'($urandom);
            endcase
            step(1, p);
            if (gaps == 1) begin
                repeat (((idx % W) == W-1) ? 5 : 2) step(0, D'($urandom));
            end else if (gaps == 2) begin
                repeat ($urandom_range(0, 3)) step(0, D'($urandom));
            end
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_window"}, 64'(window), 64'(0));
        chk({tag, "_win_valid"}, 64'(win_valid), 64'(0));
        chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    endtask

    initial begin
        logic [9*D-1:0] w;
        logic [D-1:0]   e;
        int             s;

        #3;
        reset_check("reset0");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, '0);

        got.delete();
        frame(0, 0, W*H);
        chk("s1_count", 64'(got.size()), 64'(4));
        if (got.size() == 4) begin
            chk("s1_first", 64'(got[0]), 64'(36'ha98654210));
            chk("s1_last", 64'(got[3]), 64'(36'hfedba9765));
        end
        ref1 = got;
        step(0, '0);

        got.delete();
        frame(0, 1, W*H);
        chk("s2_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("s2_same", 64'(got[i]), 64'(36'h0) | 64'(ref1[i]));

        got.delete();
        frame(0, 0, W*H);
        frame(1, 0, W*H);
        chk("s3_count", 64'(got.size()), 64'(8));
        if (got.size() == 8)
            chk("s3_f2_first", 64'(got[4]), 64'(36'h5679abdef));

        got.delete();
        frame(0, 0, 6);
        #3;
        rst_n = 1'b0;
        #1;
        reset_check("reset_async");
        @(posedge clk);
        #1;
        reset_check("reset_held");
        mr = 0;
        mc = 0;
        known = 0;
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        frame(0, 0, W*H);
        chk("s4_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("s4_same", 64'(got[i]), 64'(ref1[i]));

        got.delete();
        frame(2, 0, W*H);
        chk("s5_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < got.size(); i++) begin
            w = got[i];
            chk("s5_window", 64'(w), 64'(36'h888888888));
            s = 0;
            for (int k = 0; k < 9; k++) begin
                e = w[k*D +: D];
                s += int'($signed(e));
            end
            chk("s5_sum", 64'(s), 64'(-72));
        end

        got.delete();
        repeat (4) frame(3, 2, W*H);
        chk("s6_count", 64'(got.size()), 64'(16));
        step(0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
